// File: rtl/pio_in_debounced.sv
// Avalon-MM parallel input port with per-bit synchroniser, debounce counter
// and programmable rising/falling edge capture driving a level interrupt.
module pio_in_debounced #(
    parameter int              WIDTH       = 18,
    parameter int              SYNC_STAGES = 2,
    parameter int              DB_W        = 16,
    parameter logic [DB_W-1:0] DB_RESET    = 16'd50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [DB_W-1:0] CNT_ZERO    = {DB_W{1'b0}};
    localparam logic [DB_W-1:0] CNT_ONE     = {{(DB_W-1){1'b0}}, 1'b1};
    localparam logic [DB_W:0]   CNT_ONE_EXT = {{DB_W{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] BITS_ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] BITS_ONES  = {WIDTH{1'b1}};

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] db_r;
    logic [WIDTH-1:0] db_next_s;
    logic [WIDTH-1:0] upd_s;
    logic [WIDTH-1:0] set_s;
    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] capture_r;
    logic [WIDTH-1:0] capture_next_s;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] rise_en_r;
    logic [WIDTH-1:0] fall_en_r;
    logic [DB_W-1:0]  cnt_r      [WIDTH];
    logic [DB_W-1:0]  cnt_next_s [WIDTH];
    logic [DB_W-1:0]  thresh_r;
    logic [31:0]      rd_mux_s;
    logic [31:0]      readdata_r;
    logic             wr_s;
    logic             unused_wdata_s;

    assign wr_s           = chipselect & ~write_n;
    assign sync_s         = sync_r[SYNC_STAGES-1];
    assign unused_wdata_s = ^writedata;

    // Synchroniser chain for the asynchronous pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= BITS_ZERO;
            end
        end else begin
            sync_r[0] <= in_port;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    // Debounce next state, edge detection and W1C/set merge (set has priority)
    always_comb begin
        db_next_s = db_r;
        upd_s     = BITS_ZERO;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next_s[i] = CNT_ZERO;
            if (sync_s[i] == db_r[i]) begin
                cnt_next_s[i] = CNT_ZERO;
            end else if ((thresh_r == CNT_ZERO) ||
                         (({1'b0, cnt_r[i]} + CNT_ONE_EXT) >= {1'b0, thresh_r})) begin
                db_next_s[i] = sync_s[i];
                upd_s[i]     = 1'b1;
            end else begin
                cnt_next_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
        if (wr_s && (address == 3'd3)) begin
            clr_s = writedata[WIDTH-1:0];
        end else begin
            clr_s = BITS_ZERO;
        end
        set_s          = upd_s & ((sync_s & rise_en_r) | (~sync_s & fall_en_r));
        capture_next_s = (capture_r & ~clr_s) | set_s;
    end

    // Debounce state, capture and software-writable registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_r      <= BITS_ZERO;
            capture_r <= BITS_ZERO;
            mask_r    <= BITS_ZERO;
            rise_en_r <= BITS_ZERO;
            fall_en_r <= BITS_ONES;
            thresh_r  <= DB_RESET;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            db_r      <= db_next_s;
            capture_r <= capture_next_s;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
            if (wr_s) begin
                case (address)
                    3'd2:    mask_r    <= writedata[WIDTH-1:0];
                    3'd4:    rise_en_r <= writedata[WIDTH-1:0];
                    3'd5:    fall_en_r <= writedata[WIDTH-1:0];
                    3'd6:    thresh_r  <= writedata[DB_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Read multiplexer, zero-extended to the bus width
    always_comb begin
        rd_mux_s = 32'd0;
        case (address)
            3'd0:    rd_mux_s[WIDTH-1:0] = db_r;
            3'd1:    rd_mux_s[WIDTH-1:0] = sync_s;
            3'd2:    rd_mux_s[WIDTH-1:0] = mask_r;
            3'd3:    rd_mux_s[WIDTH-1:0] = capture_r;
            3'd4:    rd_mux_s[WIDTH-1:0] = rise_en_r;
            3'd5:    rd_mux_s[WIDTH-1:0] = fall_en_r;
            3'd6:    rd_mux_s[DB_W-1:0]  = thresh_r;
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Registered read data, one cycle behind the address phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_r <= 32'd0;
        end else begin
            readdata_r <= rd_mux_s;
        end
    end

    assign readdata = readdata_r;
    assign irq      = |(capture_r & mask_r);

endmodule
